i2c_hdmi_target: RTL

I2C_HDMI_TARGET -- requirements
Module: i2c_hdmi_target

---
 rtl/i2c_hdmi_target.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/i2c_hdmi_target.sv
// I2C register-map target for an HDMI transmitter-style control port.
// Receives a sub-address and data bytes, which it strobes out to the host register map.
// Reads return bytes from the host map, starting at the persistent register pointer.
// SDA is open-drain: the block only ever pulls it low or releases it.
module i2c_hdmi_target #(
  parameter logic [6:0] DEV_ADDR = 7'h39
) (
  input  logic       iCLK,
  input  logic       iRST_N,
  input  logic       I2C_SCLK,
  inout  wire        I2C_SDAT,
  output logic       WR_STRB,
  output logic [7:0] WR_ADDR,
  output logic [7:0] WR_DATA,
  output logic [7:0] RD_ADDR,
  input  logic [7:0] RD_DATA,
  output logic       BUSY
);

  typedef enum logic [3:0] {
    ST_IDLE, ST_DEV_ADDR, ST_DEV_ACK, ST_SUB_ADDR, ST_SUB_ACK,
    ST_WR_BYTE, ST_WR_ACK, ST_RD_BYTE, ST_RD_ACK, ST_IGNORE
  } state_t;

  state_t     stateReg, stateNext;
  logic [2:0] cntReg, cntNext;
  logic [7:0] shiftReg, shiftNext;
  logic [7:0] ptrReg, ptrNext;
  logic [7:0] wrAddrReg, wrAddrNext;
  logic [7:0] wrDataReg, wrDataNext;
  logic       sdaLowReg, sdaLowNext;
  logic       busyReg, busyNext;
  logic       strbReg, strbNext;
  logic       rwReg, rwNext;
  logic       ninthReg, ninthNext;   // set once the 9th (ACK) SCL rising edge has been seen

  logic sclMeta, sclSync, sclDly;
  logic sdaMeta, sdaSync, sdaDly;

  // Pin inputs through a 2-flop synchronizer plus one delay flop for edge detection
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      sclMeta <= 1'b1; sclSync <= 1'b1; sclDly <= 1'b1;
      sdaMeta <= 1'b1; sdaSync <= 1'b1; sdaDly <= 1'b1;
    end else begin
      sclMeta <= I2C_SCLK; sclSync <= sclMeta; sclDly <= sclSync;
      sdaMeta <= I2C_SDAT; sdaSync <= sdaMeta; sdaDly <= sdaSync;
    end
  end

  logic       sclRise, sclFall, startDet, stopDet;
  logic [7:0] rxByte;
  assign sclRise  = sclSync & ~sclDly;
  assign sclFall  = ~sclSync & sclDly;
  assign startDet = sclSync & sclDly & sdaDly & ~sdaSync;
  assign stopDet  = sclSync & sclDly & ~sdaDly & sdaSync;
  assign rxByte   = {shiftReg[6:0], sdaSync};

  // Reset also gates the driver directly so SDA is released without waiting for a clock
  assign I2C_SDAT = (sdaLowReg && iRST_N) ? 1'b0 : 1'bz;

  assign WR_STRB = strbReg;
  assign WR_ADDR = wrAddrReg;
  assign WR_DATA = wrDataReg;
  assign RD_ADDR = ptrReg;
  assign BUSY    = busyReg;

  // State and datapath registers
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      stateReg  <= ST_IDLE;
      cntReg    <= 3'd0;
      shiftReg  <= 8'd0;
      ptrReg    <= 8'd0;
      wrAddrReg <= 8'd0;
      wrDataReg <= 8'd0;
      sdaLowReg <= 1'b0;
      busyReg   <= 1'b0;
      strbReg   <= 1'b0;
      rwReg     <= 1'b0;
      ninthReg  <= 1'b0;
    end else begin
      stateReg  <= stateNext;
      cntReg    <= cntNext;
      shiftReg  <= shiftNext;
      ptrReg    <= ptrNext;
      wrAddrReg <= wrAddrNext;
      wrDataReg <= wrDataNext;
      sdaLowReg <= sdaLowNext;
      busyReg   <= busyNext;
      strbReg   <= strbNext;
      rwReg     <= rwNext;
      ninthReg  <= ninthNext;
    end
  end

  // Next-state logic: bits sampled on SCL rise, SDA drive changed only on SCL fall
  always_comb begin
    stateNext  = stateReg;
    cntNext    = cntReg;
    shiftNext  = shiftReg;
    ptrNext    = ptrReg;
    wrAddrNext = wrAddrReg;
    wrDataNext = wrDataReg;
    sdaLowNext = sdaLowReg;
    busyNext   = busyReg;
    strbNext   = 1'b0;
    rwNext     = rwReg;
    ninthNext  = ninthReg;

    if (stopDet) begin
      stateNext  = ST_IDLE;
      sdaLowNext = 1'b0;
      busyNext   = 1'b0;
      cntNext    = 3'd0;
      ninthNext  = 1'b0;
    end else if (startDet) begin
      stateNext  = ST_DEV_ADDR;
      sdaLowNext = 1'b0;
      cntNext    = 3'd0;
      ninthNext  = 1'b0;
    end else begin
      case (stateReg)
        ST_DEV_ADDR, ST_SUB_ADDR, ST_WR_BYTE: begin
          if (sclRise) begin
            shiftNext = rxByte;
            cntNext   = cntReg + 3'd1;
            if (cntReg == 3'd7) begin
              ninthNext = 1'b0;
              if (stateReg == ST_DEV_ADDR) begin
                if (rxByte[7:1] == DEV_ADDR) begin
                  stateNext = ST_DEV_ACK;
                  busyNext  = 1'b1;
                  rwNext    = rxByte[0];
                end else begin
                  stateNext = ST_IGNORE;
                  busyNext  = 1'b0;
                end
              end else if (stateReg == ST_SUB_ADDR) begin
                ptrNext   = rxByte;
                stateNext = ST_SUB_ACK;
              end else begin
                strbNext   = 1'b1;
                wrAddrNext = ptrReg;
                wrDataNext = rxByte;
                ptrNext    = ptrReg + 8'd1;
                stateNext  = ST_WR_ACK;
              end
            end
          end
        end
        ST_DEV_ACK, ST_SUB_ACK, ST_WR_ACK: begin
          if (sclRise) ninthNext = 1'b1;
          if (sclFall) begin
            if (!ninthReg) begin
              sdaLowNext = 1'b1;
            end else begin
              ninthNext = 1'b0;
              cntNext   = 3'd0;
              if (stateReg == ST_DEV_ACK && rwReg) begin
                stateNext  = ST_RD_BYTE;
                shiftNext  = RD_DATA;
                sdaLowNext = ~RD_DATA[7];
              end else begin
                stateNext  = (stateReg == ST_DEV_ACK) ? ST_SUB_ADDR : ST_WR_BYTE;
                sdaLowNext = 1'b0;
              end
            end
          end
        end
        ST_RD_BYTE: begin
          if (sclRise) begin
            cntNext = cntReg + 3'd1;
            if (cntReg == 3'd7) begin
              ptrNext   = ptrReg + 8'd1;
              stateNext = ST_RD_ACK;
              ninthNext = 1'b0;
            end
          end else if (sclFall) begin
            shiftNext  = {shiftReg[6:0], 1'b0};
            sdaLowNext = ~shiftReg[6];
          end
        end
        ST_RD_ACK: begin
          if (sclRise) begin
            if (sdaSync) begin
              stateNext = ST_IGNORE;
              busyNext  = 1'b0;
            end else begin
              ninthNext = 1'b1;
            end
          end else if (sclFall) begin
            if (!ninthReg) begin
              sdaLowNext = 1'b0;
            end else begin
              ninthNext  = 1'b0;
              cntNext    = 3'd0;
              stateNext  = ST_RD_BYTE;
              shiftNext  = RD_DATA;
              sdaLowNext = ~RD_DATA[7];
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
